// File: rtl/c7bexu_ecl_byp_if.sv
// Decode/control bundle between the issue logic and c7bexu_ecl_byp.
// master: drives D-stage tags, flush, lsu ack; slave: returns tags/selects/stall.
interface c7bexu_ecl_byp_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rd_d;
  logic              rs1_en_d;
  logic              rs2_en_d;
  logic              wen_d;
  logic              load_d;
  logic              valid_d;
  logic              flush_e;
  logic              lsu_ack_m;

  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_m;
  logic [REG_AW-1:0] rd_w;
  logic              wen_m;
  logic              wen_w;
  logic              valid_e;
  logic              ecl_byp_rs1_mux_sel_rf;
  logic              ecl_byp_rs1_mux_sel_m;
  logic              ecl_byp_rs1_mux_sel_w;
  logic              ecl_byp_rs2_mux_sel_rf;
  logic              ecl_byp_rs2_mux_sel_m;
  logic              ecl_byp_rs2_mux_sel_w;
  logic              stall_d;

  modport master (
    output rs1_d, rs2_d, rd_d,
    output rs1_en_d, rs2_en_d,
    output wen_d, load_d, valid_d,
    output flush_e, lsu_ack_m,
    input  rs1_e, rs2_e, rd_m, rd_w,
    input  wen_m, wen_w, valid_e,
    input  ecl_byp_rs1_mux_sel_rf,
    input  ecl_byp_rs1_mux_sel_m,
    input  ecl_byp_rs1_mux_sel_w,
    input  ecl_byp_rs2_mux_sel_rf,
    input  ecl_byp_rs2_mux_sel_m,
    input  ecl_byp_rs2_mux_sel_w,
    input  stall_d
  );

  modport slave (
    input  rs1_d, rs2_d, rd_d,
    input  rs1_en_d, rs2_en_d,
    input  wen_d, load_d, valid_d,
    input  flush_e, lsu_ack_m,
    output rs1_e, rs2_e, rd_m, rd_w,
    output wen_m, wen_w, valid_e,
    output ecl_byp_rs1_mux_sel_rf,
    output ecl_byp_rs1_mux_sel_m,
    output ecl_byp_rs1_mux_sel_w,
    output ecl_byp_rs2_mux_sel_rf,
    output ecl_byp_rs2_mux_sel_m,
    output ecl_byp_rs2_mux_sel_w,
    output stall_d
  );
endinterface

// File: rtl/c7bexu_ecl_byp.sv
// Bypass/hazard control: E/M/W tag pipeline, one-hot bypass selects,
// load-use and memory-wait stalls. Ports: clk, resetn, bus (slave);
// with C7BEXU_ECL_PERF_EN also perf_lu_stall_cnt / perf_mw_stall_cnt.
module c7bexu_ecl_byp #(
  parameter int REG_AW = 5
`ifdef C7BEXU_ECL_PERF_EN
  ,
  parameter int PERF_CNT_W = 32
`endif
) (
  input  logic clk,
  input  logic resetn,
  c7bexu_ecl_byp_if.slave bus
`ifdef C7BEXU_ECL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_lu_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_mw_stall_cnt
`endif
);

  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
  logic              rs1_en_e, rs2_en_e;
  logic              wen_e, load_e, valid_e;
  logic [REG_AW-1:0] rd_m;
  logic              wen_m_q, load_m, valid_m;
  logic [REG_AW-1:0] rd_w;
  logic              wen_w_q;

  logic wen_m, wen_w;
  logic lu_stall, mw_stall;
  logic e_take, e_bub;
  logic rs1_hit_m, rs1_hit_w;
  logic rs2_hit_m, rs2_hit_w;

  assign wen_m = wen_m_q & valid_m;
  assign wen_w = wen_w_q;

  assign mw_stall = valid_m & load_m & ~bus.lsu_ack_m;

  assign lu_stall =
    bus.valid_d & load_e & valid_e & wen_e &
    (rd_e != '0) &
    ((bus.rs1_en_d & (bus.rs1_d == rd_e)) |
     (bus.rs2_en_d & (bus.rs2_d == rd_e)));

  // flush wins over both stalls; mw holds E, lu only bubbles it
  assign e_take = ~bus.flush_e & ~mw_stall &
                  ~lu_stall & bus.valid_d;
  assign e_bub  = bus.flush_e |
                  (~mw_stall & ~e_take);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs1_e    <= '0;
      rs2_e    <= '0;
      rd_e     <= '0;
      rs1_en_e <= 1'b0;
      rs2_en_e <= 1'b0;
      wen_e    <= 1'b0;
      load_e   <= 1'b0;
      valid_e  <= 1'b0;
    end else if (e_take) begin
      rs1_e    <= bus.rs1_d;
      rs2_e    <= bus.rs2_d;
      rd_e     <= bus.rd_d;
      rs1_en_e <= bus.rs1_en_d;
      rs2_en_e <= bus.rs2_en_d;
      wen_e    <= bus.wen_d;
      load_e   <= bus.load_d;
      valid_e  <= 1'b1;
    end else if (e_bub) begin
      rs1_e    <= '0;
      rs2_e    <= '0;
      rd_e     <= '0;
      rs1_en_e <= 1'b0;
      rs2_en_e <= 1'b0;
      wen_e    <= 1'b0;
      load_e   <= 1'b0;
      valid_e  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_m    <= '0;
      wen_m_q <= 1'b0;
      load_m  <= 1'b0;
      valid_m <= 1'b0;
    end else if (!mw_stall) begin
      rd_m    <= rd_e;
      wen_m_q <= wen_e;
      load_m  <= load_e;
      valid_m <= valid_e;
    end
  end

  // W takes a bubble while M waits on load data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_w    <= '0;
      wen_w_q <= 1'b0;
    end else if (mw_stall) begin
      wen_w_q <= 1'b0;
    end else begin
      rd_w    <= rd_m;
      wen_w_q <= wen_m;
    end
  end

  assign rs1_hit_m = rs1_en_e & wen_m &
                     (rd_m == rs1_e) & (rs1_e != '0);
  assign rs1_hit_w = rs1_en_e & wen_w &
                     (rd_w == rs1_e) & (rs1_e != '0);
  assign rs2_hit_m = rs2_en_e & wen_m &
                     (rd_m == rs2_e) & (rs2_e != '0);
  assign rs2_hit_w = rs2_en_e & wen_w &
                     (rd_w == rs2_e) & (rs2_e != '0);

  assign bus.ecl_byp_rs1_mux_sel_m  = rs1_hit_m;
  assign bus.ecl_byp_rs1_mux_sel_w  = ~rs1_hit_m & rs1_hit_w;
  assign bus.ecl_byp_rs1_mux_sel_rf = ~(rs1_hit_m | rs1_hit_w);
  assign bus.ecl_byp_rs2_mux_sel_m  = rs2_hit_m;
  assign bus.ecl_byp_rs2_mux_sel_w  = ~rs2_hit_m & rs2_hit_w;
  assign bus.ecl_byp_rs2_mux_sel_rf = ~(rs2_hit_m | rs2_hit_w);

  assign bus.stall_d = ~bus.flush_e & (mw_stall | lu_stall);

  assign bus.rs1_e   = rs1_e;
  assign bus.rs2_e   = rs2_e;
  assign bus.rd_m    = rd_m;
  assign bus.rd_w    = rd_w;
  assign bus.wen_m   = wen_m;
  assign bus.wen_w   = wen_w;
  assign bus.valid_e = valid_e;

`ifdef C7BEXU_ECL_PERF_EN
  // lu is only counted when it actually stalls D (flush suppresses it)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_lu_stall_cnt <= '0;
      perf_mw_stall_cnt <= '0;
    end else if (mw_stall) begin
      if (perf_mw_stall_cnt != '1)
        perf_mw_stall_cnt <= perf_mw_stall_cnt + 1'b1;
    end else if (lu_stall & ~bus.flush_e) begin
      if (perf_lu_stall_cnt != '1)
        perf_lu_stall_cnt <= perf_lu_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/c7bexu_ecl_byp.md
Name: c7bexu_ecl_byp

Overview:
- Execution-control bypass/hazard block. It sits directly upstream of the c7bexu_byp datapath mux.
- Carries source and destination register tags through E/M/W pipeline registers and drives the one-hot bypass selects consumed by the mux.
- Detects load-use hazards and multi-cycle load waits, then stalls decode and inserts bubbles.
- Drives the rs1_e/rs2_e/rd_m/rd_w/wen_m/wen_w tags that c7bexu_byp compares.

Parameters:
- REG_AW, 5, register index width.
- PERF_CNT_W, 32, width of perf counters (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- rs1_d  in  REG_AW  decode-stage source 1 index.
- rs2_d  in  REG_AW  decode-stage source 2 index.
- rs1_en_d  in  1  instruction in D reads rs1.
- rs2_en_d  in  1  instruction in D reads rs2.
- rd_d  in  REG_AW  decode-stage destination index.
- wen_d  in  1  instruction in D writes rd.
- load_d  in  1  instruction in D is a load.
- valid_d  in  1  D holds a valid instruction.
- flush_e  in  1  kill instruction in E and the D->E transfer (branch redirect).
- lsu_ack_m  in  1  load data for the instruction in M is available this cycle.
- rs1_e  out  REG_AW  E-stage source 1 index.
- rs2_e  out  REG_AW  E-stage source 2 index.
- rd_m  out  REG_AW  M-stage destination index.
- rd_w  out  REG_AW  W-stage destination index.
- wen_m  out  1  M-stage write enable (valid-qualified).
- wen_w  out  1  W-stage write enable (valid-qualified).
- valid_e  out  1  E holds a valid instruction.
- ecl_byp_rs1_mux_sel_rf/_m/_w  out  1 each  one-hot rs1 select.
- ecl_byp_rs2_mux_sel_rf/_m/_w  out  1 each  one-hot rs2 select.
- stall_d  out  1  hold D (decode must not advance).

Behaviour:
Reset (resetn low, asynchronous):
- All pipeline registers clear: valid/wen/load at E/M/W = 0, all indices = 0.
- Outputs settle to: sel_rf = 1, sel_m = sel_w = 0, stall_d = 0.

Pipeline registers (E/M/W):
- E holds rs1, rs2, rs1_en, rs2_en, rd, wen, load, valid.
- M holds rd, wen, load, valid.
- W holds rd, wen.
- wen_m and wen_w are ANDed with the stage valid.

Bypass selects (combinational, from E/M/W registers):
- rsX_hit_m = rsX_en_e & wen_m & (rd_m == rsX_e) & (rsX_e != 0).
- rsX_hit_w = same test against W.
- Priority M over W.
- sel_m = hit_m; sel_w = !hit_m & hit_w; sel_rf = !(sel_m | sel_w).
- Exactly one select is high every cycle, including during stalls.
- Register x0 is never bypassed.

Load-use hazard (lu_stall):
- Condition: valid_d & load_e & valid_e & wen_e & rd_e != 0 & ((rs1_en_d & rs1_d == rd_e) | (rs2_en_d & rs2_d == rd_e)).
- Effect: stall_d = 1; E loads a bubble (valid_e = 0) next cycle; M advances normally.
- Net result: exactly one bubble, and the consumer later receives load data via the W bypass.

Memory wait (mw_stall):
- Condition: valid_m & load_m & !lsu_ack_m.
- Effect: E and M hold their contents; W loads a bubble (wen_w = 0); stall_d = 1.
- mw_stall takes priority over lu_stall. When both are true, E holds rather than bubbles.

Flush:
- flush_e = 1 makes E a bubble next cycle regardless of D; stall_d is forced to 0 that cycle.
- If flush_e coincides with mw_stall, E still clears while M holds.

Normal advance (no stall, no flush):
- D->E transfer when valid_d; otherwise E gets a bubble.
- E->M, M->W each cycle.

Latency: 1 cycle per stage. Selects are valid in the same cycle as the E contents.

Reset mid-operation: clears all state immediately. The first cycle after deassertion behaves as an empty pipeline.

Optional Feature:
- Macro C7BEXU_ECL_PERF_EN.
- When defined, adds outputs perf_lu_stall_cnt and perf_mw_stall_cnt, each PERF_CNT_W wide.
  - Each increments once per cycle its stall condition is true (mw_stall takes precedence; only one counter increments per cycle).
  - Counters saturate at all-ones, reset to 0, and are cleared by flush_e only if additionally gated — they are not cleared by flush.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: hold resetn=0 with random inputs -> all sel_rf=1, sel_m=sel_w=0, stall_d=0, wen_m=wen_w=0, valid_e=0.
- ALU chain: issue add x5 (wen), then add x6 using rs1=x5 -> next cycle rs1 sel_m=1. After an unrelated instruction, a reader of x5 sees sel_w=1. When both M and W write x5, sel_m wins.
- x0 guard: writer rd=0 followed by reader rs1=0 -> sel_rf=1 throughout.
- Load-use: lw x7, then add rs2=x7 -> stall_d=1 for exactly 1 cycle and valid_e=0 for one cycle, then rs2 sel_w=1 with no stall.
- Memory wait: load in M with lsu_ack_m=0 for 3 cycles -> stall_d=1 for 3 cycles, E/M indices unchanged, wen_w=0 during the wait, then advance on ack.
- Flush: flush_e=1 during a load-use stall -> valid_e=0 next cycle and stall_d=0 that cycle. With C7BEXU_ECL_PERF_EN, perf_lu_stall_cnt=1 and perf_mw_stall_cnt=3 after the scenarios above.
